// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame width, parity encodings, legal prescale values and FSM state enum
package uart_pkg;
  localparam int WIDTH = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam logic [5:0] PRESCALE_8 = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: serial line + frame config in, received word + status pulses out
interface uart_rx_deframer_if;
  import uart_pkg::*;
  logic rx_in;
  logic [5:0] prescale;
  logic par_en;
  logic parity_type;
  logic [WIDTH-1:0] p_data;
  logic data_valid;
  logic par_err;
  logic stp_err;
  modport master (output rx_in, prescale, par_en, parity_type, input p_data, data_valid, par_err, stp_err);
  modport slave (input rx_in, prescale, par_en, parity_type, output p_data, data_valid, par_err, stp_err);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: captures rx_in at edge_cnt P/2-1, P/2, P/2+1 and returns the 2-of-3 majority as sampled_bit
module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] prescale,
  output logic       sampled_bit
);
  logic [2:0] s_q, s_d;
  logic [5:0] mid;
  always_comb begin
    mid = prescale >> 1;
    s_d[0] = edge_cnt == mid - 6'd1 ? rx_in : s_q[0];
    s_d[1] = edge_cnt == mid ? rx_in : s_q[1];
    s_d[2] = edge_cnt == mid + 6'd1 ? rx_in : s_q[2];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) s_q <= 3'b111;
    else s_q <= s_d;
  assign sampled_bit = (s_q[0] & s_q[1]) | (s_q[0] & s_q[2]) | (s_q[1] & s_q[2]);
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive FSM; ports clk, rst (async active-low), bus (slave: rx_in/config in, p_data/status out)
module uart_rx_deframer
  import uart_pkg::*;
(
  input logic clk,
  input logic rst,
  uart_rx_deframer_if.slave bus
);
  localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);
  uart_state_e state_q, state_d;
  logic [5:0] edge_cnt_q, edge_cnt_d, p_q, p_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic par_en_q, par_en_d, par_type_q, par_type_d, par_fail_q, par_fail_d;
  logic [WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic valid_q, valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic sampled_bit, bit_end;
  uart_rx_sampler u_sampler (
    .clk(clk),
    .rst(rst),
    .rx_in(bus.rx_in),
    .edge_cnt(edge_cnt_q),
    .prescale(p_q),
    .sampled_bit(sampled_bit)
  );
  assign bit_end = edge_cnt_q == p_q - 6'd1;
  always_comb begin
    state_d = state_q;
    edge_cnt_d = edge_cnt_q;
    p_d = p_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d = par_en_q;
    par_type_d = par_type_q;
    par_fail_d = par_fail_q;
    shift_d = shift_q;
    p_data_d = p_data_q;
    valid_d = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    if (state_q == IDLE) begin
      edge_cnt_d = 6'd0;
      if (!bus.rx_in) begin
        // detection cycle is edge_cnt 0 of the start bit, so the next cycle is edge 1
        state_d = START;
        edge_cnt_d = 6'd1;
        p_d = bus.prescale;
        par_en_d = bus.par_en;
        par_type_d = bus.parity_type;
        bit_cnt_d = 3'd0;
        par_fail_d = 1'b0;
      end
    end else begin
      edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
      if (bit_end)
        case (state_q)
          START: state_d = sampled_bit ? IDLE : DATA;
          DATA: begin
            shift_d = {sampled_bit, shift_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
          end
          PARITY: begin
            par_fail_d = sampled_bit != (par_type_q == PAR_ODD ? ~^shift_q : ^shift_q);
            state_d = STOP;
          end
          STOP: begin
            p_data_d = shift_q;
            stp_err_d = !sampled_bit;
            par_err_d = par_fail_q;
            valid_d = sampled_bit && !par_fail_q;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      edge_cnt_q <= 6'd0;
      p_q <= PRESCALE_8;
      bit_cnt_q <= 3'd0;
      par_en_q <= 1'b0;
      par_type_q <= PAR_EVEN;
      par_fail_q <= 1'b0;
      shift_q <= '0;
      p_data_q <= '0;
      valid_q <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_cnt_q <= edge_cnt_d;
      p_q <= p_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q <= par_en_d;
      par_type_q <= par_type_d;
      par_fail_q <= par_fail_d;
      shift_q <= shift_d;
      p_data_q <= p_data_d;
      valid_q <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  assign bus.p_data = p_data_q;
  assign bus.data_valid = valid_q;
  assign bus.par_err = par_err_q;
  assign bus.stp_err = stp_err_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: frame-level model of expected status pulses checked every cycle, plus literal latency/output pins
module tb_uart_rx_deframer;
  import uart_pkg::*;
  typedef struct {
    int cyc;
    logic [7:0] data;
    logic [2:0] fl;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_t0 = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [7:0] m_data = 8'h00;
  uart_rx_deframer_if bus ();
  uart_rx_deframer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask
  always @(negedge clk) begin
    logic [2:0] ef;
    ef = 3'b000;
    if (!rst) begin
      m_data = 8'h00;
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ef = exp_q[0].fl;
      m_data = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("cycle_outputs", {21'd0, bus.data_valid, bus.par_err, bus.stp_err, bus.p_data}, {21'd0, ef, m_data});
    if (bus.data_valid || bus.par_err || bus.stp_err)
      obs_q.push_back('{cyc, bus.p_data, {bus.data_valid, bus.par_err, bus.stp_err}});
  end
  task automatic send_frame(input int p, input bit pen, input bit pt, input logic [7:0] d,
                            input bit pbit, input bit stop, input int abort_bits);
    logic bits[$];
    bit pe, se;
    int t0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stop);
    pe = pen && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
    se = !stop;
    t0 = cyc;
    bus.prescale = 6'(p);
    bus.par_en = pen;
    bus.parity_type = pt;
    if (abort_bits == 0) exp_q.push_back('{t0 + bits.size() * p, d, {!pe && !se, pe, se}});
    for (int i = 0; i < bits.size() && (abort_bits == 0 || i < abort_bits); i++) begin
      bus.rx_in = bits[i];
      if (i == 1) begin
        bus.prescale = p == 8 ? PRESCALE_16 : PRESCALE_8;
        bus.par_en = !pen;
        bus.parity_type = !pt;
      end
      repeat (p) begin
        @(posedge clk);
        #1;
      end
    end
    bus.rx_in = 1'b1;
    last_t0 = t0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pin(input string name, input int t0, input int lat, input logic [2:0] fl, input logic [7:0] d);
    ev_t e;
    e = '{-1, 8'h00, 3'b000};
    if (obs_q.size() > 0) e = obs_q.pop_front();
    chk({name, "_latency"}, e.cyc - t0, lat);
    chk({name, "_status_data"}, {21'd0, e.fl, e.data}, {21'd0, fl, d});
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0a;
    bus.rx_in = 1'b1;
    bus.prescale = PRESCALE_8;
    bus.par_en = 1'b0;
    bus.parity_type = PAR_EVEN;
    idle(3);
    chk("reset_outputs", {21'd0, bus.data_valid, bus.par_err, bus.stp_err, bus.p_data}, 32'd0);
    rst = 1'b1;
    idle(2);
    send_frame(8, 1'b1, PAR_EVEN, 8'hA5, 1'b0, 1'b1, 0);
    idle(2);
    pin("a5_even", last_t0, 88, 3'b100, 8'hA5);
    send_frame(16, 1'b1, PAR_ODD, 8'h3C, 1'b0, 1'b1, 0);
    idle(2);
    pin("3c_odd_bad", last_t0, 176, 3'b010, 8'h3C);
    send_frame(8, 1'b0, PAR_EVEN, 8'hFF, 1'b0, 1'b0, 0);
    idle(2);
    pin("ff_stop0", last_t0, 80, 3'b001, 8'hFF);
    bus.prescale = PRESCALE_8;
    bus.rx_in = 1'b0;
    idle(2);
    bus.rx_in = 1'b1;
    idle(6);
    chk("glitch_no_pulse", obs_q.size(), 0);
    chk("glitch_pdata_held", {24'd0, bus.p_data}, 32'h0000_00FF);
    send_frame(32, 1'b0, PAR_EVEN, 8'h01, 1'b0, 1'b1, 0);
    t0a = last_t0;
    send_frame(32, 1'b0, PAR_EVEN, 8'h80, 1'b0, 1'b1, 0);
    idle(2);
    pin("b2b_first", t0a, 320, 3'b100, 8'h01);
    pin("b2b_second", t0a, 640, 3'b100, 8'h80);
    send_frame(8, 1'b0, PAR_EVEN, 8'hC3, 1'b0, 1'b1, 4);
    rst = 1'b0;
    idle(3);
    chk("midreset_outputs", {21'd0, bus.data_valid, bus.par_err, bus.stp_err, bus.p_data}, 32'd0);
    rst = 1'b1;
    idle(2);
    chk("midreset_no_pulse", obs_q.size(), 0);
    send_frame(8, 1'b0, PAR_EVEN, 8'h5A, 1'b0, 1'b1, 0);
    idle(2);
    pin("post_reset_5a", last_t0, 80, 3'b100, 8'h5A);
    chk("model_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive-side framing and parity checker for the UART: oversamples the serial line, recovers start/data/parity/stop bits, checks parity and stop bit, and delivers the parallel word with a one-cycle valid strobe. It is the receive-direction counterpart of the transmit path's parity calculation and framing. It uses the same parity-type encoding, so both ends of a link are configured identically.

## Interface
- Width, 8, data bits per frame (LSB first on the line)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rx_in  input  1  serial line, idle high; already synchronised to clk externally
- prescale  input  6  oversampling ratio P; legal values 8, 16, 32
- par_en  input  1  1 = frame carries a parity bit after the data
- parity_type  input  1  1 = odd, 0 = even
- p_data  output  Width  received data word
- data_valid  output  1  one-cycle pulse, frame received with no error
- par_err  output  1  one-cycle pulse, parity mismatch
- stp_err  output  1  one-cycle pulse, stop bit sampled 0

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when rx_in = 0 on a clock edge (detection cycle t0). prescale, par_en and parity_type are latched at t0 and held for the whole frame; changes mid-frame are ignored.
- edge_cnt counts 0..P-1 per bit; t0 is edge_cnt 0 of the start bit. bit_cnt counts data bits 0..Width-1.
- Each bit is sampled at edge_cnt P/2-1, P/2, P/2+1. Bit value = majority of the 3 samples.
- Bit decisions and state changes happen at edge_cnt = P-1.
- START: a majority of 1 means a glitch. Return to IDLE with no output pulse. A majority of 0 goes to DATA.
- DATA: shift the majority bit into the shift register LSB-first. After bit Width-1, go to PARITY if par_en, else STOP.
- PARITY: the expected bit is ^data (even) or ~^data (odd). A mismatch sets the internal parity-fail flag.
- STOP: at edge_cnt P-1, p_data is loaded with the shift register whether or not the frame has an error.
  - stp_err = (stop majority == 0).
  - par_err = parity-fail flag (always 0 when par_en = 0).
  - data_valid = !stp_err && !par_err.
  - All three are registered and pulse for exactly one cycle; the FSM returns to IDLE.
- Back-to-back frames: a start bit is detected on the first cycle after returning to IDLE. No idle gap is required.
- Illegal prescale values: behaviour is unspecified and the verification engineer does not check it.

## Timing
- Reset: FSM = IDLE, counters = 0, p_data = 0, data_valid = par_err = stp_err = 0. Reset mid-frame aborts the frame with no pulse.
- Frame length: N = 1 + Width + par_en + 1 bits.
- Status pulse latency: the status pulse is asserted during cycle t0 + N·P. Example: Width 8, par_en 1, P 8 gives t0 + 88.
- p_data changes on the same edge as the status pulse and holds until the next frame end.
- data_valid and par_err/stp_err are mutually exclusive. par_err and stp_err may pulse together.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum, shared with the TX framer;
  - parity-type constants PAR_EVEN = 0, PAR_ODD = 1;
  - the legal prescale constants.
- Sub-module uart_rx_sampler holds the three-point sampling registers and majority vote. It takes edge_cnt and P and returns sampled_bit.
- The top level holds the FSM, edge/bit counters, shift register, parity check and output registers.

## Test plan
- P = 8, par_en = 1, even parity, byte 0xA5 (even parity bit 0), stop 1 → at t0 + 88: data_valid = 1, p_data = 0xA5, no errors.
- P = 16, par_en = 1, odd parity, byte 0x3C sent with wrong parity bit 0 → at t0 + 176: par_err = 1, data_valid = 0, p_data = 0x3C.
- P = 8, par_en = 0, byte 0xFF, stop bit driven 0 → at t0 + 80: stp_err = 1, data_valid = 0.
- P = 8, rx_in low for 2 cycles then high (start glitch) → FSM back to IDLE after 8 cycles; no pulse; p_data unchanged.
- P = 32, two back-to-back frames 0x01 then 0x80, no idle gap, par_en = 0 → two data_valid pulses, 320 cycles apart, with the correct p_data each.
- Assert rst mid-DATA, then release and send 0x5A with P = 8, par_en = 0 → outputs are 0 during reset, no pulse for the aborted frame, then a clean data_valid with p_data = 0x5A.
